// File: rtl/addsub_seq_pkg.sv
// rtl/addsub_seq_pkg.sv - shared types and constants for the sequenced add/sub controller
package addsub_seq_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/addsub_slice4.sv
// rtl/addsub_slice4.sv - combinational 4-bit add slice with carry in/out
module addsub_slice4
   import addsub_seq_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   logic [SLICE_W:0] total;

   always_comb begin
      total = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
      sum   = total[SLICE_W-1:0];
      cout  = total[SLICE_W];
   end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// rtl/addsub_seq_ctrl.sv - WIDTH-bit add/sub computed one nibble per cycle; ADDSUB_SEQ_OVF_EN adds the ovf port
module addsub_seq_ctrl
   import addsub_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout
`ifdef ADDSUB_SEQ_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               sub_q, sub_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               cout_q, cout_d;
   logic               out_valid_q, out_valid_d;
`ifdef ADDSUB_SEQ_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   logic [SLICE_W-1:0] slice_a;
   logic [SLICE_W-1:0] slice_b;
   logic [SLICE_W-1:0] slice_sum;
   logic               slice_cout;

   // b is inverted here so the slice stays a plain adder; carry_q supplies the +1
   always_comb begin
      slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
      slice_b = b_q[idx_q*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_q}};
   end

   addsub_slice4 u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sub_d    = sub_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      result_d = result_q;
      cout_d   = cout_q;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d      = a;
               b_d      = b;
               sub_d    = sub;
               carry_d  = sub;
               idx_d    = '0;
               result_d = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            result_d[idx_q*SLICE_W +: SLICE_W] = slice_sum;
            carry_d = slice_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = slice_cout;
`ifdef ADDSUB_SEQ_OVF_EN
               ovf_d   = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q)) &&
                         (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
`endif
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         result_q    <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sub_q       <= sub_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         result_q    <= result_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
`ifdef ADDSUB_SEQ_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign cout      = cout_q;
`ifdef ADDSUB_SEQ_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// tb/tb_addsub_seq_ctrl.sv - directed self-checking bench for addsub_seq_ctrl (WIDTH=16)
module tb_addsub_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        cout;
`ifdef ADDSUB_SEQ_OVF_EN
   logic        ovf;
`endif

   int n_cmp;
   int n_bad;

   addsub_seq_ctrl #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout)
`ifdef ADDSUB_SEQ_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offers one operand, scrambles the inputs after acceptance, returns cycles to out_valid.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                        output int lat);
      int n;
      @(negedge clk);
      a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; a = ~ta; b = 16'h5A5A; sub = ~ts;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic do_release;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_ready cyc%0d got %b want 0", i, in_ready);
         end
      end
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_out_valid got %b want 0", out_valid); end
      n_cmp++;
      if (result !== 16'h0000) begin n_bad++; $display("FAIL post_reset_result got %h want 0000", result); end
      n_cmp++;
      if (cout !== 1'b0) begin n_bad++; $display("FAIL post_reset_cout got %b want 0", cout); end
   endtask

   task automatic test_add;
      int lat;
      do_op(16'h1234, 16'h0FF0, 1'b0, lat);
      n_cmp++;
      if (lat !== 4) begin n_bad++; $display("FAIL add_latency got %0d want 4", lat); end
      n_cmp++;
      if (result !== 16'h2224) begin n_bad++; $display("FAIL add_result got %h want 2224", result); end
      n_cmp++;
      if (cout !== 1'b0) begin n_bad++; $display("FAIL add_cout got %b want 0", cout); end
`ifdef ADDSUB_SEQ_OVF_EN
      n_cmp++;
      if (ovf !== 1'b0) begin n_bad++; $display("FAIL add_ovf got %b want 0", ovf); end
`endif
      do_release;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_release_in_ready got %b want 1", in_ready); end
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_release_out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_sub;
      int lat;
      do_op(16'h0007, 16'h0005, 1'b1, lat);
      n_cmp++;
      if (lat !== 4) begin n_bad++; $display("FAIL sub_pos_latency got %0d want 4", lat); end
      n_cmp++;
      if (result !== 16'h0002) begin n_bad++; $display("FAIL sub_pos_result got %h want 0002", result); end
      n_cmp++;
      if (cout !== 1'b1) begin n_bad++; $display("FAIL sub_pos_cout got %b want 1", cout); end
      do_release;
      do_op(16'h0005, 16'h0007, 1'b1, lat);
      n_cmp++;
      if (result !== 16'hFFFE) begin n_bad++; $display("FAIL sub_neg_result got %h want fffe", result); end
      n_cmp++;
      if (cout !== 1'b0) begin n_bad++; $display("FAIL sub_neg_cout got %b want 0", cout); end
      do_release;
   endtask

   task automatic test_ripple;
      int lat;
      do_op(16'hFFFF, 16'h0001, 1'b0, lat);
      n_cmp++;
      if (lat !== 4) begin n_bad++; $display("FAIL ripple_latency got %0d want 4", lat); end
      n_cmp++;
      if (result !== 16'h0000) begin n_bad++; $display("FAIL ripple_result got %h want 0000", result); end
      n_cmp++;
      if (cout !== 1'b1) begin n_bad++; $display("FAIL ripple_cout got %b want 1", cout); end
      do_release;
   endtask

`ifdef ADDSUB_SEQ_OVF_EN
   task automatic test_ovf;
      int lat;
      do_op(16'h7FFF, 16'h0001, 1'b0, lat);
      n_cmp++;
      if (result !== 16'h8000) begin n_bad++; $display("FAIL ovf_add_result got %h want 8000", result); end
      n_cmp++;
      if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_add_ovf got %b want 1", ovf); end
      n_cmp++;
      if (cout !== 1'b0) begin n_bad++; $display("FAIL ovf_add_cout got %b want 0", cout); end
      do_release;
      do_op(16'h8000, 16'h0001, 1'b1, lat);
      n_cmp++;
      if (result !== 16'h7FFF) begin n_bad++; $display("FAIL ovf_sub_result got %h want 7fff", result); end
      n_cmp++;
      if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sub_ovf got %b want 1", ovf); end
      n_cmp++;
      if (cout !== 1'b1) begin n_bad++; $display("FAIL ovf_sub_cout got %b want 1", cout); end
      do_release;
   endtask
`endif

   task automatic test_backpressure;
      int lat;
      do_op(16'h0007, 16'h0005, 1'b1, lat);
      n_cmp++;
      if (result !== 16'h0002) begin n_bad++; $display("FAIL bp_first_result got %h want 0002", result); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
         n_cmp++;
         if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_out_valid cyc%0d got %b want 1", i, out_valid); end
         n_cmp++;
         if (result !== 16'h0002) begin n_bad++; $display("FAIL bp_hold_result cyc%0d got %h want 0002", i, result); end
         n_cmp++;
         if (cout !== 1'b1) begin n_bad++; $display("FAIL bp_hold_cout cyc%0d got %b want 1", i, cout); end
         n_cmp++;
         if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_in_ready cyc%0d got %b want 0", i, in_ready); end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_idle_in_ready got %b want 1", in_ready); end
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle_out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
      in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_accept_in_ready got %b want 0", in_ready); end
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      n_cmp++;
      if (lat !== 4) begin n_bad++; $display("FAIL bp_second_latency got %0d want 4", lat); end
      n_cmp++;
      if (result !== 16'h3333) begin n_bad++; $display("FAIL bp_second_result got %h want 3333", result); end
      n_cmp++;
      if (cout !== 1'b0) begin n_bad++; $display("FAIL bp_second_cout got %b want 0", cout); end
      do_release;
   endtask

   task automatic test_reset_mid_run;
      int  lat;
      logic seen;
      @(negedge clk);
      a = 16'hAAAA; b = 16'h5555; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midrun_reset_in_ready got %b want 0", in_ready); end
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_bad++; $display("FAIL midrun_no_out_valid got %b want 0", seen); end
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrun_idle_in_ready got %b want 1", in_ready); end
      do_op(16'h00FF, 16'h0001, 1'b0, lat);
      n_cmp++;
      if (lat !== 4) begin n_bad++; $display("FAIL midrun_next_latency got %0d want 4", lat); end
      n_cmp++;
      if (result !== 16'h0100) begin n_bad++; $display("FAIL midrun_next_result got %h want 0100", result); end
      n_cmp++;
      if (cout !== 1'b0) begin n_bad++; $display("FAIL midrun_next_cout got %b want 0", cout); end
      do_release;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset;
      test_add;
      test_sub;
      test_ripple;
`ifdef ADDSUB_SEQ_OVF_EN
      test_ovf;
`endif
      test_backpressure;
      test_reset_mid_run;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/addsub_seq_ctrl.md
# addsub_seq_ctrl

Sequencing controller that computes a WIDTH-bit add or subtract by reusing one 4-bit add/sub slice over WIDTH/4 consecutive cycles, least-significant nibble first. A carry register links the slices. Operands arrive on a valid/ready input handshake, and the result leaves on a valid/ready output handshake. It sits between an operand source and any consumer that trades latency for a small ripple datapath.

## Interface
- WIDTH, 16: operand/result width; multiple of 4, ≥ 8. NSLICE = WIDTH/4.
- Clocking (decided): one clock; reset is synchronous and active-low.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  controller can accept an operand.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- sub  in  1  0: a+b; 1: a−b.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  out  1  final carry. Add: unsigned overflow. Sub: 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow. Present only with ADDSUB_SEQ_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: latch a, b, sub; carry ← sub; idx ← 0; result ← 0; go to RUN.
- RUN (in_ready=0)
  - Slice inputs: a[4·idx+:4], b[4·idx+:4] XOR {4{sub}}, carry.
  - Each cycle: result[4·idx+:4] ← slice sum; carry ← slice cout; idx ← idx+1.
  - When idx==NSLICE−1: cout ← slice cout; go to DONE.
- DONE
  - out_valid=1; result and cout held stable.
  - On out_ready: go to IDLE.
- Subtraction is two's complement: a + ~b + 1. The +1 is the initial carry=sub.
- Operands are captured only at acceptance. Later changes on a/b/sub have no effect.
- in_valid while not in IDLE: ignored; the requester must hold it.
- out_ready while out_valid=0: ignored.
- idx width: clog2(NSLICE). It never wraps; the FSM leaves RUN at NSLICE−1.
- Reset values: state=IDLE, out_valid=0, result=0, cout=0, ovf=0, carry=0, idx=0.
- in_ready is forced to 0 while rst_n=0.
- Reset mid-RUN or mid-DONE: the operation is discarded, no out_valid is produced, and the next accepted operation computes correctly.

## Timing
- Acceptance edge: the edge where in_valid & in_ready. out_valid rises exactly NSLICE cycles later (4 cycles for WIDTH=16).
- out_valid and result are registered outputs.
- in_ready is combinational from state (and rst_n) only. There is no combinational path from in_valid or out_ready to any output.
- Output handshake completes on the edge with out_valid & out_ready. in_ready is 1 on the following cycle.
- Minimum spacing between acceptances: NSLICE+2 cycles.
- DONE may be held indefinitely by out_ready=0.

## Configuration
- ADDSUB_SEQ_OVF_EN defined:
  - ovf port exists.
  - On the last slice: ovf ← (a_msb == beff_msb) & (sum_msb != a_msb), with beff = b XOR sub.
  - ovf is valid with out_valid and resets to 0.
- Undefined: no ovf port, no ovf logic. All other behaviour is identical.

## Structure
- Package addsub_seq_pkg:
  - state enum {IDLE, RUN, DONE}
  - SLICE_W=4
- Sub-module addsub_slice4: purely combinational 4-bit ripple full-adder slice.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: sum[3:0], cout.
  - Instantiated once; the controller performs the b XOR sub inversion.

## Test plan
- Reset: hold rst_n=0 for 2 cycles during in_valid=1 → in_ready=0 during reset; after release in_ready=1, out_valid=0, result=0x0000, cout=0.
- Add, WIDTH=16: 0x1234+0x0FF0 → result=0x2224, cout=0, with out_valid exactly 4 cycles after acceptance.
- Subtract: 0x0007−0x0005 → 0x0002, cout=1. 0x0005−0x0007 → 0xFFFE, cout=0.
- Full ripple: 0xFFFF+0x0001 → 0x0000, cout=1. With macro: 0x7FFF+0x0001 → 0x8000, ovf=1; 0x8000−0x0001 → 0x7FFF, ovf=1.
- Backpressure: out_ready=0 for 5 cycles in DONE → result/cout stable, in_ready=0, a new in_valid is not accepted; once out_ready=1 it is accepted one cycle after IDLE.
- Reset mid-RUN (rst_n=0 at second RUN cycle) → no out_valid; the next op 0x00FF+0x0001 → 0x0100.
